// File: rtl/mux_pkg.sv
// Shared constants for the registered select mux: select-width helper, occupancy
// state encoding and the default data width.
package mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Ceil log2 of n, never less than 1.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Handshake bundle between operand sources, mux_n_reg and the next pipeline stage.
interface mux_n_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_reg_skid_buf.sv
// Two-entry skid buffer: main register drives the outputs, skid register absorbs
// one word of backpressure so in_ready never depends combinationally on out_ready.
module skid_buf
  import mux_pkg::*;
#(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept_c, deliver_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Occupancy transitions; handshake flags are precomputed for the next cycle.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    accept_c  = in_valid && in_ready_q;
    deliver_c = out_valid_q && out_ready;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept_c && deliver_c) begin
          main_d = in_data;
        end else if (accept_c) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (deliver_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/mux_n_reg.sv
// N-input registered select mux with valid/ready handshake and skid buffering.
// Optional sticky out-of-range select flag enabled by MUX_N_REG_SELERR_EN.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input logic          clk,
  input logic          rst,
  mux_n_reg_if.slave   bus
);

  localparam int unsigned PW = WIDTH + SEL_W;

  logic [WIDTH-1:0] sel_data;
  logic [PW-1:0]    payload_out;

  // Out-of-range selects fall back to input 0.
  always_comb begin
    sel_data = bus.in_data[WIDTH-1:0];
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({bus.in_sel, sel_data}),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (payload_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.out_data = payload_out[WIDTH-1:0];
  assign bus.out_sel  = payload_out[PW-1:WIDTH];

`ifdef MUX_N_REG_SELERR_EN
  logic sel_err_q;
  logic accept_c;

  assign accept_c = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (accept_c && (32'(bus.in_sel) >= N)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg (N=3/WIDTH=32) plus a randomised handshake stream
// on a second instance (N=5/WIDTH=8) checked against a FIFO scoreboard.
module tb_mux_n_reg;

`ifdef MUX_N_REG_SELERR_EN
  localparam bit SELERR = 1'b1;
`else
  localparam bit SELERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mux_n_reg_if #(.WIDTH(32), .N(3), .SEL_W(2)) ia ();
  mux_n_reg_if #(.WIDTH(8),  .N(5), .SEL_W(3)) ib ();

  mux_n_reg #(.WIDTH(32), .N(3), .SEL_W(2)) u_a (.clk(clk), .rst(rst), .bus(ia));
  mux_n_reg #(.WIDTH(8),  .N(5), .SEL_W(3)) u_b (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {sel, byte} for the N=5, WIDTH=8 instance.
  function automatic logic [10:0] model_b(input logic [39:0] d, input logic [2:0] s);
    logic [7:0] v;
    v = (s < 3'd5) ? d[32'(s)*8 +: 8] : d[7:0];
    return {s, v};
  endfunction

  logic [10:0] q[$];
  logic [10:0] held;
  logic [10:0] exp_w;
  logic        stall_prev;
  logic        acc;
  logic        del;

  initial begin
    errors = 0;
    checks = 0;
    stall_prev = 1'b0;
    held = '0;
    ia.in_data = '0; ia.in_sel = '0; ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    ib.in_data = '0; ib.in_sel = '0; ib.in_valid = 1'b0; ib.out_ready = 1'b0;

    // Reset, with in_valid asserted to show it is ignored.
    rst = 1'b1;
    ia.in_valid = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data",  ia.out_data,       32'd0);
    chk("rst_out_sel",   32'(ia.out_sel),   32'd0);
    chk("rst_in_ready",  32'(ia.in_ready),  32'd1);
    chk("rst_sel_err",   32'(ia.sel_err),   32'd0);
    chk("rst_b_valid",   32'(ib.out_valid), 32'd0);
    ia.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(ia.out_valid), 32'd0);

    // Stream sel 0,1,2 at full throughput.
    ia.in_data = {32'h3, 32'h2, 32'h1};
    ia.out_ready = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_sel = 2'd0;
    tick();
    chk("s0_valid", 32'(ia.out_valid), 32'd1);
    chk("s0_data",  ia.out_data,       32'h1);
    chk("s0_ready", 32'(ia.in_ready),  32'd1);
    ia.in_sel = 2'd1;
    tick();
    chk("s1_data",  ia.out_data,       32'h2);
    chk("s1_sel",   32'(ia.out_sel),   32'd1);
    chk("s1_ready", 32'(ia.in_ready),  32'd1);
    ia.in_sel = 2'd2;
    tick();
    chk("s2_data",  ia.out_data,       32'h3);
    chk("s2_sel",   32'(ia.out_sel),   32'd2);
    chk("s2_ready", 32'(ia.in_ready),  32'd1);
    ia.in_valid = 1'b0;
    tick();
    chk("s_drain_valid", 32'(ia.out_valid), 32'd0);

    // Out-of-range select falls back to input 0.
    ia.in_data = {32'h3, 32'h2, 32'hDEAD_BEEF};
    ia.in_sel = 2'd3;
    ia.in_valid = 1'b1;
    tick();
    chk("oor_data",    ia.out_data,       32'hDEAD_BEEF);
    chk("oor_sel",     32'(ia.out_sel),   32'd3);
    chk("oor_sel_err", 32'(ia.sel_err),   32'(SELERR));
    ia.in_valid = 1'b0;
    ia.in_sel = 2'd0;
    tick();
    chk("oor_drain",   32'(ia.out_valid), 32'd0);
    chk("oor_sticky",  32'(ia.sel_err),   32'(SELERR));

    // Backpressure fills the skid register.
    ia.out_ready = 1'b0;
    ia.in_data = {32'h3, 32'h2, 32'h11};
    ia.in_valid = 1'b1;
    tick();
    chk("bp1_data",  ia.out_data,      32'h11);
    chk("bp1_ready", 32'(ia.in_ready), 32'd1);
    ia.in_data = {32'h3, 32'h2, 32'h22};
    tick();
    chk("bp2_data",  ia.out_data,      32'h11);
    chk("bp2_ready", 32'(ia.in_ready), 32'd0);
    ia.in_data = {32'h3, 32'h2, 32'h33};
    tick();
    chk("bp3_data",  ia.out_data,       32'h11);
    chk("bp3_valid", 32'(ia.out_valid), 32'd1);
    chk("bp3_ready", 32'(ia.in_ready),  32'd0);
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    tick();
    chk("bp4_data",  ia.out_data,      32'h22);
    chk("bp4_ready", 32'(ia.in_ready), 32'd1);
    tick();
    chk("bp5_valid", 32'(ia.out_valid), 32'd0);

    // Accept and deliver together in ONE.
    ia.out_ready = 1'b0;
    ia.in_data = {32'h3, 32'h2, 32'h44};
    ia.in_valid = 1'b1;
    tick();
    chk("ad1_data", ia.out_data, 32'h44);
    ia.out_ready = 1'b1;
    ia.in_data = {32'h3, 32'h2, 32'h55};
    tick();
    chk("ad2_data",  ia.out_data,      32'h55);
    chk("ad2_ready", 32'(ia.in_ready), 32'd1);
    ia.in_valid = 1'b0;
    tick();
    chk("ad3_valid", 32'(ia.out_valid), 32'd0);

    // Reset while FULL discards both words.
    ia.out_ready = 1'b0;
    ia.in_data = {32'h3, 32'h2, 32'h66};
    ia.in_valid = 1'b1;
    tick();
    ia.in_data = {32'h3, 32'h2, 32'h77};
    tick();
    chk("full_ready", 32'(ia.in_ready), 32'd0);
    ia.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("frst_valid",   32'(ia.out_valid), 32'd0);
    chk("frst_ready",   32'(ia.in_ready),  32'd1);
    chk("frst_sel_err", 32'(ia.sel_err),   32'd0);
    chk("frst_data",    ia.out_data,       32'd0);
    ia.out_ready = 1'b1;
    tick();
    chk("frst_stale1", 32'(ia.out_valid), 32'd0);
    tick();
    chk("frst_stale2", 32'(ia.out_valid), 32'd0);

    // Random handshake stream on the N=5 instance.
    for (int c = 0; c < 10000; c++) begin
      chk("b_valid", 32'(ib.out_valid), 32'(q.size() != 0));
      chk("b_ready", 32'(ib.in_ready),  32'(q.size() < 2));
      if (stall_prev) chk("b_stable", 32'({ib.out_sel, ib.out_data}), 32'(held));
      ib.in_valid  = 1'($urandom_range(0, 1));
      ib.out_ready = 1'($urandom_range(0, 1));
      ib.in_sel    = 3'($urandom_range(0, 7));
      ib.in_data   = {8'($urandom), 32'($urandom)};
      acc = ib.in_valid && ib.in_ready;
      del = ib.out_valid && ib.out_ready;
      if (del && q.size() != 0) begin
        exp_w = q.pop_front();
        chk("b_order", 32'({ib.out_sel, ib.out_data}), 32'(exp_w));
      end
      if (acc) q.push_back(model_b(ib.in_data, ib.in_sel));
      stall_prev = ib.out_valid && !ib.out_ready;
      held = {ib.out_sel, ib.out_data};
      tick();
    end

    // Drain remaining words.
    ib.in_valid = 1'b0;
    ib.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (ib.out_valid && q.size() != 0) begin
        exp_w = q.pop_front();
        chk("b_drain", 32'({ib.out_sel, ib.out_data}), 32'(exp_w));
      end
      tick();
    end
    chk("b_empty_valid", 32'(ib.out_valid), 32'd0);
    chk("b_empty_queue", 32'(q.size()),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
